// File: rtl/inst_prefetch_queue_pkg.sv
// Shared types and constants for the instruction prefetch queue.
// State encoding, PC step and the FIFO entry layout.
package inst_prefetch_queue_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_DISCARD = 2'd2
  } state_t;

  localparam int unsigned WORD_BYTES = 4;
  localparam logic [31:0] PC_INC = 32'(WORD_BYTES);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  function automatic logic [31:0] align_pc(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/inst_prefetch_queue_fifo.sv
// DEPTH-entry FIFO of {pc, inst} pairs with synchronous flush.
// Pointers and count reset asynchronously; storage is not reset.
module prefetch_fifo
  import inst_prefetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned CW = AW + 1
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic          i_flush,
  input  fetch_entry_t  i_data,
  output fetch_entry_t  o_head,
  output logic [CW-1:0] o_count
);

  fetch_entry_t  r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic          w_do_pop;
  logic          w_do_push;

  assign w_do_pop  = i_pop & (r_count != '0);
  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign w_do_push = i_push &
                     ((r_count != CW'(DEPTH)) | w_do_pop);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
      r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_do_push & ~i_flush) r_mem[r_wptr] <= i_data;
  end

  assign o_head  = r_mem[r_rptr];
  assign o_count = r_count;

endmodule

// File: rtl/inst_prefetch_queue.sv
// Fetch front end: owns the fetch PC, issues req/ack reads to imem,
// buffers results and handles redirects by flushing and restarting.
module inst_prefetch_queue
  import inst_prefetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  localparam int unsigned CW = $clog2(DEPTH) + 1
) (
  input  logic          i_clk,
  input  logic          i_rst,
  output logic          o_imem_req,
  output logic [31:0]   o_imem_addr,
  input  logic          i_imem_ack,
  input  logic [31:0]   i_imem_rdata,
  output logic          o_inst_valid,
  output logic [31:0]   o_inst,
  output logic [31:0]   o_inst_pc,
  output logic [31:0]   o_inst_pc4,
  input  logic          i_inst_ready,
  input  logic          i_redirect,
  input  logic [31:0]   i_redirect_pc,
  output logic [CW-1:0] o_count
);

  localparam logic [CW:0] LP_DEPTH = (CW+1)'(DEPTH);

  state_t        r_state;
  logic [31:0]   r_fetch_pc;
  logic [31:0]   r_addr;
  logic          r_req;

  logic          w_ack;
  logic          w_pop;
  logic          w_push;
  logic          w_space;
  logic [CW-1:0] w_count;
  logic [CW:0]   w_cnt_nxt;
  logic [31:0]   w_tgt;
  logic [31:0]   w_pc_inc;
  fetch_entry_t  w_head;
  fetch_entry_t  w_wdata;

  assign w_ack     = r_req & i_imem_ack;
  assign w_pop     = o_inst_valid & i_inst_ready;
  assign w_push    = (r_state == ST_REQ) & w_ack & ~i_redirect;
  assign w_cnt_nxt = {1'b0, w_count} + (CW+1)'(w_push)
                   - (CW+1)'(w_pop);
  assign w_space   = w_cnt_nxt < LP_DEPTH;
  assign w_tgt     = align_pc(i_redirect_pc);
  assign w_pc_inc  = r_fetch_pc + PC_INC;
  assign w_wdata   = '{pc: r_fetch_pc, inst: i_imem_rdata};

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= ST_IDLE;
      r_fetch_pc <= RESET_PC;
      r_addr     <= RESET_PC;
      r_req      <= 1'b0;
    end else if (i_redirect) begin
      r_fetch_pc <= w_tgt;
      // An outstanding request must still see its ack before restarting.
      if (r_req & ~w_ack) begin
        r_state <= ST_DISCARD;
      end else begin
        r_state <= ST_REQ;
        r_req   <= 1'b1;
        r_addr  <= w_tgt;
      end
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_space) begin
            r_state <= ST_REQ;
            r_req   <= 1'b1;
            r_addr  <= r_fetch_pc;
          end
        end
        ST_REQ: begin
          if (w_ack) begin
            r_fetch_pc <= w_pc_inc;
            if (w_space) begin
              r_addr <= w_pc_inc;
            end else begin
              r_state <= ST_IDLE;
              r_req   <= 1'b0;
            end
          end
        end
        ST_DISCARD: begin
          if (w_ack) begin
            r_state <= ST_REQ;
            r_addr  <= r_fetch_pc;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_req   <= 1'b0;
        end
      endcase
    end
  end

  prefetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (i_redirect),
    .i_data  (w_wdata),
    .o_head  (w_head),
    .o_count (w_count)
  );

  assign o_imem_req   = r_req;
  assign o_imem_addr  = r_addr;
  assign o_inst_valid = (w_count != '0);
  assign o_inst       = w_head.inst;
  assign o_inst_pc    = w_head.pc;
  assign o_inst_pc4   = w_head.pc + PC_INC;
  assign o_count      = w_count;

endmodule

// File: tb/tb_inst_prefetch_queue.sv
// Bench for inst_prefetch_queue: directed table, corner sequences and
// randomized traffic against a queue-based reference model.
module tb_inst_prefetch_queue;

  localparam int          DEPTH  = 4;
  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] KEY    = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic [31:0] inst_pc4;
  logic        inst_ready = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [2:0]  count;

  always #5 clk = ~clk;

  // Memory returns a tag derived from the requested address.
  assign imem_rdata = imem_addr ^ KEY;

  inst_prefetch_queue #(
    .DEPTH   (DEPTH),
    .RESET_PC(RST_PC)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .o_imem_req   (imem_req),
    .o_imem_addr  (imem_addr),
    .i_imem_ack   (imem_ack),
    .i_imem_rdata (imem_rdata),
    .o_inst_valid (inst_valid),
    .o_inst       (inst),
    .o_inst_pc    (inst_pc),
    .o_inst_pc4   (inst_pc4),
    .i_inst_ready (inst_ready),
    .i_redirect   (redirect),
    .i_redirect_pc(redirect_pc),
    .o_count      (count)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Reference model: a queue of fetched words plus the fetch pointer.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  ent_t        mq[$];
  bit          m_req;
  bit          m_drop;
  logic [31:0] m_pc;
  logic [31:0] m_addr;

  task automatic model_reset();
    mq.delete();
    m_req  = 0;
    m_drop = 0;
    m_pc   = RST_PC;
    m_addr = RST_PC;
  endtask

  task automatic model_edge(input bit ack, input bit rdy, input bit rd,
                            input logic [31:0] rpc);
    bit          acc;
    bit          pop;
    logic [31:0] tgt;
    acc = m_req && ack;
    pop = (mq.size() != 0) && rdy;
    tgt = {rpc[31:2], 2'b00};
    if (rd) begin
      mq.delete();
      m_pc = tgt;
      if (m_req && !acc) begin
        m_drop = 1;
      end else begin
        m_drop = 0;
        m_req  = 1;
        m_addr = tgt;
      end
    end else begin
      if (pop) void'(mq.pop_front());
      if (acc && m_drop) begin
        m_drop = 0;
        m_addr = m_pc;
      end else if (acc) begin
        mq.push_back('{pc: m_addr, inst: m_addr ^ KEY});
        m_pc = m_addr + 32'd4;
        if (mq.size() < DEPTH) m_addr = m_pc;
        else m_req = 0;
      end else if (!m_req && mq.size() < DEPTH) begin
        m_req  = 1;
        m_addr = m_pc;
      end
    end
  endtask

  task automatic check_all();
    chk("req", {31'b0, imem_req}, {31'b0, m_req});
    if (m_req) chk("addr", imem_addr, m_addr);
    chk("valid", {31'b0, inst_valid}, {31'b0, mq.size() != 0});
    chk("count", {29'b0, count}, 32'(mq.size()));
    if (mq.size() != 0) begin
      chk("inst_pc", inst_pc, mq[0].pc);
      chk("inst", inst, mq[0].inst);
      chk("inst_pc4", inst_pc4, mq[0].pc + 32'd4);
    end
  endtask

  task automatic step(input bit ack, input bit rdy, input bit rd,
                      input logic [31:0] rpc);
    imem_ack    = ack;
    inst_ready  = rdy;
    redirect    = rd;
    redirect_pc = rpc;
    @(posedge clk);
    model_edge(ack, rdy, rd, rpc);
    #1;
    check_all();
  endtask

  // Asynchronous reset applied between edges, released mid-cycle.
  task automatic do_reset();
    imem_ack = 1'b1;
    redirect = 1'b0;
    rst = 1'b1;
    model_reset();
    #1;
    chk("rst_req", {31'b0, imem_req}, 32'd0);
    chk("rst_valid", {31'b0, inst_valid}, 32'd0);
    chk("rst_count", {29'b0, count}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    bit          ack;
    bit          rdy;
    bit          rd;
    logic [31:0] rpc;
    bit          e_req;
    logic [31:0] e_addr;
    int          e_cnt;
    logic [31:0] e_pc;
  } vec_t;

  vec_t tbl[16];

  initial begin
    tbl[0]  = '{1, 0, 0, 32'h0,   1, 32'h0,   0, 32'h0};
    tbl[1]  = '{1, 0, 0, 32'h0,   1, 32'h4,   1, 32'h0};
    tbl[2]  = '{1, 0, 0, 32'h0,   1, 32'h8,   2, 32'h0};
    tbl[3]  = '{1, 0, 0, 32'h0,   1, 32'hC,   3, 32'h0};
    tbl[4]  = '{1, 0, 0, 32'h0,   0, 32'h0,   4, 32'h0};
    tbl[5]  = '{1, 0, 0, 32'h0,   0, 32'h0,   4, 32'h0};
    tbl[6]  = '{1, 1, 0, 32'h0,   1, 32'h10,  3, 32'h4};
    tbl[7]  = '{1, 1, 0, 32'h0,   1, 32'h14,  3, 32'h8};
    tbl[8]  = '{0, 1, 0, 32'h0,   1, 32'h14,  2, 32'hC};
    tbl[9]  = '{0, 1, 0, 32'h0,   1, 32'h14,  1, 32'h10};
    tbl[10] = '{0, 1, 0, 32'h0,   1, 32'h14,  0, 32'h0};
    tbl[11] = '{0, 0, 1, 32'h103, 1, 32'h14,  0, 32'h0};
    tbl[12] = '{1, 1, 0, 32'h0,   1, 32'h100, 0, 32'h0};
    tbl[13] = '{1, 0, 0, 32'h0,   1, 32'h104, 1, 32'h100};
    tbl[14] = '{1, 0, 1, 32'h200, 1, 32'h200, 0, 32'h0};
    tbl[15] = '{1, 1, 0, 32'h0,   1, 32'h204, 1, 32'h200};

    model_reset();
    #2;
    chk("reset_req", {31'b0, imem_req}, 32'd0);
    chk("reset_addr", imem_addr, RST_PC);
    chk("reset_valid", {31'b0, inst_valid}, 32'd0);
    chk("reset_count", {29'b0, count}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Directed table: fill with ready low, drain, redirects.
    for (int i = 0; i < 16; i++) begin
      step(tbl[i].ack, tbl[i].rdy, tbl[i].rd, tbl[i].rpc);
      chk($sformatf("tbl%0d_req", i), {31'b0, imem_req},
          {31'b0, tbl[i].e_req});
      if (tbl[i].e_req)
        chk($sformatf("tbl%0d_addr", i), imem_addr, tbl[i].e_addr);
      chk($sformatf("tbl%0d_cnt", i), {29'b0, count},
          32'(tbl[i].e_cnt));
      if (tbl[i].e_cnt != 0)
        chk($sformatf("tbl%0d_pc", i), inst_pc, tbl[i].e_pc);
    end

    // Reset while a request is outstanding.
    do_reset();
    step(1, 1, 0, 32'h0);
    chk("post_rst_req", {31'b0, imem_req}, 32'd1);
    chk("post_rst_addr", imem_addr, RST_PC);

    // Redirect near the top of the address space; PC wraps to zero.
    step(1, 1, 1, 32'hFFFF_FFF8);
    chk("wrap_addr", imem_addr, 32'hFFFF_FFF8);
    step(1, 1, 0, 32'h0);
    chk("wrap_pc0", inst_pc, 32'hFFFF_FFF8);
    step(1, 1, 0, 32'h0);
    chk("wrap_pc1", inst_pc, 32'hFFFF_FFFC);
    chk("wrap_pc4", inst_pc4, 32'h0000_0000);
    step(1, 1, 0, 32'h0);
    chk("wrap_pc2", inst_pc, 32'h0000_0000);

    // Latency-3 memory with a redirect while the request is pending.
    step(0, 1, 0, 32'h0);
    step(0, 1, 1, 32'h0000_0103);
    chk("disc_valid", {31'b0, inst_valid}, 32'd0);
    step(0, 1, 0, 32'h0);
    step(1, 1, 0, 32'h0);
    chk("disc_addr", imem_addr, 32'h0000_0100);
    for (int i = 0; i < 9; i++) step((i % 3) == 2, 1, 0, 32'h0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) begin
        do_reset();
      end else begin
        step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
             $urandom_range(0, 19) == 0, $urandom);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/inst_prefetch_queue.md
Name: inst_prefetch_queue

Overview:
- Instruction fetch front end that sits directly upstream of the single-cycle datapath.
- Owns the fetch PC and issues word reads to an instruction memory with variable latency, using a req/ack handshake.
- Buffers returned instructions with their PCs in a small FIFO and presents them to decode with a valid/ready handshake.
- Accepts branch/jump redirects from the datapath: flushes buffered and in-flight fetches, then restarts at the target.

Parameters:
- DEPTH, 4, FIFO entries (power of two, >=2).
- RESET_PC, 32'h0000_0000, fetch address after reset (word aligned).

Ports:
- clock  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- imem_req  out  1  read request, registered; held until imem_ack.
- imem_addr  out  32  word address of the request; stable while imem_req=1.
- imem_ack  in  1  request completes on the edge where req=1 and ack=1.
- imem_rdata  in  32  instruction word, valid with imem_ack.
- inst_valid  out  1  head entry valid (count!=0).
- inst  out  32  head instruction.
- inst_pc  out  32  PC of head instruction.
- inst_pc4  out  32  inst_pc+4, mod 2^32.
- inst_ready  in  1  decode consumes head on edge where valid&ready.
- redirect  in  1  branch/jump taken; one-cycle pulse.
- redirect_pc  in  32  new fetch target; bits[1:0] forced to 0.
- count  out  3  entries held, 0..DEPTH (width clog2(DEPTH)+1).

Behaviour:
- Reset (async, immediate): state=IDLE, fetch_pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, FIFO pointers=0, count=0, inst_valid=0. inst/inst_pc have no defined value while inst_valid=0.
- States: IDLE, REQ, DISCARD.
  - IDLE: if space (count_next < DEPTH) -> REQ with imem_addr=fetch_pc, req=1.
  - REQ, no ack: hold req and addr.
  - REQ, ack: push {imem_rdata, fetch_pc}; fetch_pc+=4.
    - If space remains after this push and same-edge pop -> stay REQ, addr=new fetch_pc.
    - Otherwise -> IDLE, req=0.
  - DISCARD: req stays 1 to honour the handshake; the next ack is dropped (no push); then -> REQ at fetch_pc.
- Throughput and latency:
  - With a zero-wait memory (ack tied high), one instruction per cycle.
  - First req is asserted one edge after Reset deasserts.
  - Fetch-to-valid latency is one edge after the ack edge.
- Space computation: count_next = count + push - pop. Full FIFO with a same-edge pop still permits the push.
- Dequeue: on valid&ready, head pointer advances and count decrements. Pop when empty is ignored.
- Redirect (highest priority):
  - Clears FIFO (count=0, pointers=0); the same-edge pop is irrelevant.
  - fetch_pc = {redirect_pc[31:2],2'b00}.
  - If state=REQ without ack -> DISCARD, and imem_addr keeps the old address until that ack.
  - If state=REQ with ack on the same edge -> the ack data is dropped and the next state is REQ at the new PC.
  - If state=IDLE -> REQ at the new PC.
  - If state=DISCARD -> stay DISCARD (or go to REQ if the ack arrives on that edge); fetch_pc is updated.
  - inst_valid=0 on the cycle after any redirect.
- Wrap-around:
  - Pointers wrap mod DEPTH.
  - fetch_pc 32'hFFFF_FFFC + 4 -> 32'h0000_0000.
  - inst_pc4 wraps the same way.
- imem_ack while req=0 is ignored.
- Reset asserted mid-REQ drops req immediately; any later ack is ignored.

Decomposition:
- Shared package: state encoding (IDLE=2'd0, REQ=2'd1, DISCARD=2'd2), WORD_BYTES=4, PC_INC=32'd4.
- Sub-module prefetch_fifo: DEPTH x 64-bit storage {pc, inst}.
  - Ports: push/pop/flush, head outputs, count.
  - Async-reset pointers; storage needs no reset.
- Top level holds the FSM, fetch_pc and redirect logic.

Test Plan:
- Zero-wait memory, ready=1, rdata=addr^32'hA5A5_0000 -> addresses 0,4,8,...; inst_pc matches; inst correct; one instruction per cycle; count<=1.
- ready=0, zero-wait memory -> exactly 4 acks accepted, req drops, count=4. Raise ready -> drains in order 0,4,8,12, fetching resumes at 16.
- Ack latency 3, redirect to 32'h0000_0103 while req pending -> pending ack data never appears; next req addr=32'h0000_0100; FIFO empty the cycle after redirect.
- Redirect on the same edge as an ack from 0x40 (target 0x200) -> 0x40 data dropped; next imem_addr=0x200 with req=1; no DISCARD cycle.
- Reset pulsed between edges while req=1 -> req=0 and inst_valid=0 immediately; after release, first req addr=RESET_PC.
- Redirect to 32'hFFFF_FFF8, zero-wait memory -> inst_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000; inst_pc4 of FFFF_FFFC equals 0.
